// File: rtl/reg_bank_wb_pkg.sv
// Shared CPU constants: register-file geometry, destination-select encodings,
// and the stack/link register indices used by both write-back and the register bank.
package reg_bank_wb_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned SP_IDX   = 29;
    localparam int unsigned RA_IDX   = 31;
    localparam int unsigned SP_RESET = 227;

    typedef enum logic [1:0] {
        DST_RT = 2'd0,
        DST_RD = 2'd1,
        DST_RA = 2'd2,
        DST_SP = 2'd3
    } dst_sel_e;

endpackage

// File: rtl/reg_bank_wb_dst_mux.sv
// 4:1 write-destination index select; shared with hazard and trace logic.
module reg_dst_mux
    import reg_bank_wb_pkg::*;
#(
    parameter int unsigned ADDR_BITS = ADDR_W,
    parameter int unsigned SP_INDEX  = SP_IDX,
    parameter int unsigned RA_INDEX  = RA_IDX
) (
    input  logic [1:0]           dst_sel,
    input  logic [ADDR_BITS-1:0] rt,
    input  logic [ADDR_BITS-1:0] rd,
    output logic [ADDR_BITS-1:0] wr_idx
);

    always_comb begin
        wr_idx = rt;
        case (dst_sel_e'(dst_sel))
            DST_RT:  wr_idx = rt;
            DST_RD:  wr_idx = rd;
            DST_RA:  wr_idx = ADDR_BITS'(RA_INDEX);
            DST_SP:  wr_idx = ADDR_BITS'(SP_INDEX);
            default: wr_idx = rt;
        endcase
    end

endmodule

// File: rtl/reg_bank_wb.sv
// General-purpose register bank: write-back, two bypassed read ports and
// the A/B operand holding registers.
module reg_bank_wb
    import reg_bank_wb_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_W,
    parameter int unsigned ADDR_BITS = ADDR_W,
    parameter int unsigned SP_INDEX  = SP_IDX,
    parameter int unsigned SP_INIT   = SP_RESET,
    parameter int unsigned RA_INDEX  = RA_IDX
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reg_write,
    input  logic [1:0]           dst_sel,
    input  logic [ADDR_BITS-1:0] rs,
    input  logic [ADDR_BITS-1:0] rt,
    input  logic [ADDR_BITS-1:0] rd,
    input  logic [DATA_BITS-1:0] wb_data,
    input  logic                 load_ab,
    output logic [DATA_BITS-1:0] rs_data,
    output logic [DATA_BITS-1:0] rt_data,
    output logic [DATA_BITS-1:0] a_out,
    output logic [DATA_BITS-1:0] b_out,
    output logic [ADDR_BITS-1:0] wr_idx
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_BITS;

    logic [DATA_BITS-1:0] regs [NUM_REGS];

    reg_dst_mux #(
        .ADDR_BITS (ADDR_BITS),
        .SP_INDEX  (SP_INDEX),
        .RA_INDEX  (RA_INDEX)
    ) u_dst_mux (
        .dst_sel (dst_sel),
        .rt      (rt),
        .rd      (rd),
        .wr_idx  (wr_idx)
    );

    // Read ports: index 0 is hardwired to zero, otherwise an in-flight write wins.
    always_comb begin
        rs_data = regs[rs];
        if (rs == '0) begin
            rs_data = '0;
        end else if (reg_write && (wr_idx == rs)) begin
            rs_data = wb_data;
        end
    end

    always_comb begin
        rt_data = regs[rt];
        if (rt == '0) begin
            rt_data = '0;
        end else if (reg_write && (wr_idx == rt)) begin
            rt_data = wb_data;
        end
    end

    // Reset clears everything but the stack pointer and drops any pending write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == SP_INDEX) ? DATA_BITS'(SP_INIT) : '0;
            end
            a_out <= '0;
            b_out <= '0;
        end else begin
            if (reg_write && (wr_idx != '0)) begin
                regs[wr_idx] <= wb_data;
            end
            if (load_ab) begin
                a_out <= rs_data;
                b_out <= rt_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_wb.sv
// Directed bench for reg_bank_wb: an array-based reference model checked on every
// falling edge, plus hand-computed literal expectations along the test plan.
module tb_reg_bank_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [1:0]  dst_sel;
    logic [4:0]  rs, rt, rd;
    logic [31:0] wb_data;
    logic        load_ab;
    logic [31:0] rs_data, rt_data, a_out, b_out;
    logic [4:0]  wr_idx;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_a, m_b;
    bit          model_valid = 1'b0;
    bit          done        = 1'b0;

    reg_bank_wb dut (
        .clk       (clk),
        .reset     (reset),
        .reg_write (reg_write),
        .dst_sel   (dst_sel),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .wb_data   (wb_data),
        .load_ab   (load_ab),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .a_out     (a_out),
        .b_out     (b_out),
        .wr_idx    (wr_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] dst_of(input logic [1:0] s, input logic [4:0] t_idx,
                                          input logic [4:0] d_idx);
        case (s)
            2'd0:    return t_idx;
            2'd1:    return d_idx;
            2'd2:    return 5'd31;
            default: return 5'd29;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (reg_write && dst_of(dst_sel, rt, rd) == idx) return wb_data;
        return m_regs[idx];
    endfunction

    // Reference model state update at each rising edge.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = (i == 29) ? 32'd227 : 32'd0;
            m_a = 32'd0;
            m_b = 32'd0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            logic [31:0] ra, rb;
            logic [4:0]  d;
            ra = model_read(rs);
            rb = model_read(rt);
            d  = dst_of(dst_sel, rt, rd);
            if (load_ab) begin
                m_a = ra;
                m_b = rb;
            end
            if (reg_write && d != 5'd0) m_regs[d] = wb_data;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (model_valid && !done) begin
            chk("model_wr_idx", 32'(wr_idx), 32'(dst_of(dst_sel, rt, rd)));
            chk("model_rs_data", rs_data, model_read(rs));
            chk("model_rt_data", rt_data, model_read(rt));
            chk("model_a_out", a_out, m_a);
            chk("model_b_out", b_out, m_b);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_write = 1'b0;
        load_ab   = 1'b0;
    endtask

    task automatic wr(input logic [1:0] s, input logic [4:0] t_idx, input logic [4:0] d_idx,
                      input logic [31:0] data);
        reg_write = 1'b1;
        dst_sel   = s;
        rt        = t_idx;
        rd        = d_idx;
        wb_data   = data;
    endtask

    initial begin
        reset = 1'b0; reg_write = 1'b0; dst_sel = 2'd0; rs = '0; rt = '0; rd = '0;
        wb_data = '0; load_ab = 1'b0;
        cyc();
        reset = 1'b1;

        // Reset values across all indices.
        chk("reset_a_out", a_out, 32'd0);
        chk("reset_b_out", b_out, 32'd0);
        for (int i = 0; i < 32; i++) begin
            rs = 5'(i);
            rt = 5'(i);
            #2;
            chk($sformatf("reset_reg%0d", i), rs_data, (i == 29) ? 32'd227 : 32'd0);
            cyc();
        end

        // Write to register 0 is dropped, bypass never fires for 0.
        wr(2'd1, 5'd3, 5'd0, 32'hDEADBEEF);
        rs = 5'd0;
        #2;
        chk("wr0_idx", 32'(wr_idx), 32'd0);
        chk("wr0_bypass", rs_data, 32'd0);
        cyc();
        idle();
        #2;
        chk("wr0_after", rs_data, 32'd0);
        cyc();

        // Destination select: RA then rt.
        wr(2'd2, 5'd0, 5'd0, 32'h00400008);
        #2;
        chk("dst_ra_idx", 32'(wr_idx), 32'd31);
        cyc();
        wr(2'd0, 5'd8, 5'd0, 32'd5);
        cyc();
        idle();
        rs = 5'd31;
        rt = 5'd8;
        #2;
        chk("dst_ra_val", rs_data, 32'h00400008);
        chk("dst_rt_val", rt_data, 32'd5);
        cyc();

        // Stack pointer destination.
        wr(2'd3, 5'd0, 5'd0, 32'h55);
        #2;
        chk("dst_sp_idx", 32'(wr_idx), 32'd29);
        cyc();
        idle();
        rs = 5'd29;
        #2;
        chk("dst_sp_val", rs_data, 32'h55);
        cyc();

        // Bypass plus capture of the same register.
        wr(2'd1, 5'd0, 5'd9, 32'd1);
        cyc();
        wr(2'd1, 5'd9, 5'd9, 32'h77);
        rs = 5'd9;
        load_ab = 1'b1;
        #2;
        chk("byp_rs", rs_data, 32'h77);
        chk("byp_rt", rt_data, 32'h77);
        cyc();
        idle();
        #2;
        chk("cap_a", a_out, 32'h77);
        chk("cap_b", b_out, 32'h77);
        chk("cap_reg9", rs_data, 32'h77);
        cyc();

        // Reset has priority over write and capture.
        wr(2'd1, 5'd0, 5'd5, 32'h1234);
        rs = 5'd5;
        load_ab = 1'b1;
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        idle();
        rs = 5'd5;
        rt = 5'd29;
        #2;
        chk("rstpri_reg5", rs_data, 32'd0);
        chk("rstpri_sp", rt_data, 32'd227);
        chk("rstpri_a", a_out, 32'd0);
        chk("rstpri_b", b_out, 32'd0);
        cyc();

        // Hold: A keeps its value while rs's register changes.
        wr(2'd1, 5'd0, 5'd10, 32'hA);
        cyc();
        idle();
        rs = 5'd10;
        load_ab = 1'b1;
        cyc();
        load_ab = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wr(2'd1, 5'd0, 5'd10, 32'h100 + 32'(k));
            #2;
            chk($sformatf("hold_rs_track%0d", k), rs_data, 32'h100 + 32'(k));
            cyc();
            chk($sformatf("hold_a%0d", k), a_out, 32'hA);
        end
        idle();
        #2;
        chk("hold_final_rs", rs_data, 32'h102);
        cyc();

        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
